// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control bus layout and register-file helpers.
package pipe_pkg;

  localparam int unsigned CTRL_W    = 8;
  localparam int unsigned REG_ADDR_W = 5;

  // Bit positions inside the decoded control bus
  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_ALU_OP_LSB = 5;
  localparam int unsigned CTRL_ALU_OP_W   = 3;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and the combined stall request for PC and IF/ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_use,
  input  logic                  id_rs2_use,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  lu_c,
  output logic                  stall_c
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_rs1_use && (id_rs1_addr == ex_rd_addr);
    rs2_hit = id_rs2_use && (id_rs2_addr == ex_rd_addr);
    lu_c    = ex_valid && ex_mem_read && (ex_rd_addr != REG_ZERO) && id_valid
              && (rs1_hit || rs2_hit);
    // A redirect kills the dependent instruction, so there is nothing to hold
    stall_c = (lu_c || ex_stall) && !flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with WB->ID bypass, load-use bubbling, flush and EX back-pressure.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              wb_write_i,
  input  logic [4:0]        wb_rd_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              flush_i,
  input  logic              ex_stall_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [4:0]        ex_rs1_addr_o,
  output logic [4:0]        ex_rs2_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  import pipe_pkg::*;

  logic              lu_c;
  logic [XLEN-1:0]   op1_c;
  logic [XLEN-1:0]   op2_c;
  logic [CTRL_W-1:0] id_ctrl_c;

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_valid_o),
    .ex_mem_read (ex_ctrl_o[CTRL_MEM_READ]),
    .ex_rd_addr  (ex_rd_addr_o),
    .id_valid    (id_valid_i),
    .id_rs1_addr (id_rs1_addr_i),
    .id_rs2_addr (id_rs2_addr_i),
    .id_rs1_use  (id_rs1_use_i),
    .id_rs2_use  (id_rs2_use_i),
    .ex_stall    (ex_stall_i),
    .flush       (flush_i),
    .lu_c        (lu_c),
    .stall_c     (stall_o)
  );

  // Register file writes on the same edge it is read, so WB data must be forwarded here
  always_comb begin
    op1_c = rs1_data_i;
    op2_c = rs2_data_i;
    if (wb_write_i && (wb_rd_addr_i != REG_ZERO) && (wb_rd_addr_i == id_rs1_addr_i)) begin
      op1_c = wb_data_i;
    end
    if (wb_write_i && (wb_rd_addr_i != REG_ZERO) && (wb_rd_addr_i == id_rs2_addr_i)) begin
      op2_c = wb_data_i;
    end
  end

  // Invalid slots carry no side effects; writes to x0 are suppressed at the source
  always_comb begin
    id_ctrl_c = '0;
    if (id_valid_i) begin
      id_ctrl_c = id_ctrl_i;
    end
    if (id_rd_addr_i == REG_ZERO) begin
      id_ctrl_c[CTRL_REG_WRITE] = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
      ex_imm_o      <= '0;
      ex_ctrl_o     <= '0;
      bubble_cnt_o  <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= '0;
    end else if (ex_stall_i) begin
      ex_valid_o <= ex_valid_o;
    end else if (lu_c) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= '0;
      if (bubble_cnt_o != '1) begin
        bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      end
    end else begin
      ex_valid_o    <= id_valid_i;
      ex_pc_o       <= id_pc_i;
      ex_rs1_data_o <= op1_c;
      ex_rs2_data_o <= op2_c;
      ex_rs1_addr_o <= id_rs1_addr_i;
      ex_rs2_addr_o <= id_rs2_addr_i;
      ex_rd_addr_o  <= id_rd_addr_i;
      ex_imm_o      <= id_imm_i;
      ex_ctrl_o     <= id_ctrl_c;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX slot contents queued at drive time, checked after each edge.
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W = 4;

  logic              clock_i;
  logic              rst_n_i;
  logic              id_valid_i;
  logic [XLEN-1:0]   id_pc_i;
  logic [4:0]        id_rs1_addr_i;
  logic [4:0]        id_rs2_addr_i;
  logic              id_rs1_use_i;
  logic              id_rs2_use_i;
  logic [4:0]        id_rd_addr_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic [XLEN-1:0]   rs1_data_i;
  logic [XLEN-1:0]   rs2_data_i;
  logic              wb_write_i;
  logic [4:0]        wb_rd_addr_i;
  logic [XLEN-1:0]   wb_data_i;
  logic              flush_i;
  logic              ex_stall_i;
  logic              stall_o;
  logic              ex_valid_o;
  logic [XLEN-1:0]   ex_pc_o;
  logic [XLEN-1:0]   ex_rs1_data_o;
  logic [XLEN-1:0]   ex_rs2_data_o;
  logic [4:0]        ex_rs1_addr_o;
  logic [4:0]        ex_rs2_addr_o;
  logic [4:0]        ex_rd_addr_o;
  logic [XLEN-1:0]   ex_imm_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clock_i(clock_i), .rst_n_i(rst_n_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
    .id_rd_addr_i(id_rd_addr_i), .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .wb_write_i(wb_write_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .ex_stall_i(ex_stall_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_imm_o(ex_imm_o), .ex_ctrl_o(ex_ctrl_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  typedef struct packed {
    logic             full;   // 0: only valid/ctrl/cnt are defined
    logic             valid;
    logic [31:0]      pc;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [4:0]       a1;
    logic [4:0]       a2;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic [7:0]       ctrl;
    logic [3:0]       cnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt = 4'd0;

  localparam logic [7:0] C_ADD = 8'h01;
  localparam logic [7:0] C_LW  = 8'h1B;

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  function automatic exp_t mk(input logic full, input logic v, input logic [31:0] pc,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic [7:0] ctrl, input logic [3:0] cnt);
    exp_t e;
    e.full = full; e.valid = v; e.pc = pc; e.rs1 = r1; e.rs2 = r2;
    e.a1 = a1; e.a2 = a2; e.rd = rd; e.imm = imm; e.ctrl = ctrl; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t get_obs();
    return mk(1'b1, ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_rs1_addr_o,
              ex_rs2_addr_o, ex_rd_addr_o, ex_imm_o, ex_ctrl_o, bubble_cnt_o);
  endfunction

  // Fill the don't-care fields of a partial expectation so only defined fields are compared
  function automatic exp_t dc_fill(input exp_t e, input exp_t o);
    exp_t r;
    r = o;
    r.valid = e.valid;
    r.ctrl  = e.ctrl;
    r.cnt   = e.cnt;
    return e.full ? e : r;
  endfunction

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] a1,
                        input logic [4:0] a2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic [31:0] imm, input logic [7:0] ctrl,
                        input logic [31:0] d1, input logic [31:0] d2);
    id_valid_i = v; id_pc_i = pc; id_rs1_addr_i = a1; id_rs2_addr_i = a2;
    id_rs1_use_i = u1; id_rs2_use_i = u2; id_rd_addr_i = rd; id_imm_i = imm;
    id_ctrl_i = ctrl; rs1_data_i = d1; rs2_data_i = d2;
  endtask

  task automatic set_wb(input logic w, input logic [4:0] rd, input logic [31:0] d);
    wb_write_i = w; wb_rd_addr_i = rd; wb_data_i = d;
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic bump_cnt();
    if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    #3;
    e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    o = get_obs();
    checks++;
    if (o !== e || stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_initial: got %h stall %b exp %h stall 0", o, stall_o, e);
    end
    @(negedge clock_i);
    rst_n_i = 1'b1;
    set_id(1, 32'h40, 5'd3, 5'd4, 1, 1, 5'd6, 32'h8, C_ADD, 32'hA, 32'hB);
    sb.push_back(mk(1, 1, 32'h40, 32'hA, 32'hB, 5'd3, 5'd4, 5'd6, 32'h8, C_ADD, 0));
    step();
    e = sb.pop_front();
    o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_first_load: got %h exp %h", o, e); end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n_i = 1'b0;
    #1;
    e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_async_clear: got %h exp %h", o, e); end
    @(negedge clock_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_bypass();
    exp_t e, o;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin
          set_id(1, 32'h100, 5'd5, 5'd6, 1, 1, 5'd9, 32'h4, C_ADD, 32'h0, 32'h22);
          set_wb(1, 5'd5, 32'hDEADBEEF);
          sb.push_back(mk(1, 1, 32'h100, 32'hDEADBEEF, 32'h22, 5'd5, 5'd6, 5'd9, 32'h4, C_ADD, exp_cnt));
        end
        1: begin
          set_id(1, 32'h104, 5'd0, 5'd6, 1, 1, 5'd9, 32'h8, C_ADD, 32'h0, 32'h22);
          set_wb(1, 5'd0, 32'hDEADBEEF);
          sb.push_back(mk(1, 1, 32'h104, 32'h0, 32'h22, 5'd0, 5'd6, 5'd9, 32'h8, C_ADD, exp_cnt));
        end
        2: begin
          set_id(1, 32'h108, 5'd5, 5'd6, 1, 1, 5'd10, 32'hC, 8'h21, 32'h55, 32'h0);
          set_wb(1, 5'd6, 32'h12345678);
          sb.push_back(mk(1, 1, 32'h108, 32'h55, 32'h12345678, 5'd5, 5'd6, 5'd10, 32'hC, 8'h21, exp_cnt));
        end
        3: begin
          set_id(1, 32'h10C, 5'd1, 5'd2, 1, 1, 5'd0, 32'h0, 8'h31, 32'h1, 32'h2);
          set_wb(0, 5'd1, 32'hFFFF0000);
          sb.push_back(mk(1, 1, 32'h10C, 32'h1, 32'h2, 5'd1, 5'd2, 5'd0, 32'h0, 8'h30, exp_cnt));
        end
        default: begin
          set_id(0, 32'h110, 5'd1, 5'd2, 1, 1, 5'd3, 32'h0, C_LW, 32'h1, 32'h2);
          set_wb(0, 0, 0);
          sb.push_back(mk(1, 0, 32'h110, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 32'h0, 8'h00, exp_cnt));
        end
      endcase
      step();
      e = sb.pop_front();
      o = get_obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL bypass_%0d: got %h exp %h", i, o, e); end
    end
  endtask

  task automatic test_load_use();
    exp_t e, o;
    logic exp_stall;
    for (int i = 0; i < 5; i++) begin
      exp_stall = 1'b0;
      case (i)
        0: begin
          set_id(1, 32'h200, 5'd2, 5'd0, 1, 0, 5'd7, 32'h10, C_LW, 32'h1000, 32'h0);
          sb.push_back(mk(1, 1, 32'h200, 32'h1000, 32'h0, 5'd2, 5'd0, 5'd7, 32'h10, C_LW, exp_cnt));
        end
        1: begin
          set_id(1, 32'h204, 5'd7, 5'd1, 1, 1, 5'd8, 32'h0, C_ADD, 32'h0, 32'h11);
          exp_stall = 1'b1;
          bump_cnt();
          sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, exp_cnt));
        end
        2: begin
          set_id(1, 32'h204, 5'd7, 5'd1, 1, 1, 5'd8, 32'h0, C_ADD, 32'h77, 32'h11);
          sb.push_back(mk(1, 1, 32'h204, 32'h77, 32'h11, 5'd7, 5'd1, 5'd8, 32'h0, C_ADD, exp_cnt));
        end
        3: begin
          set_id(1, 32'h208, 5'd2, 5'd0, 1, 0, 5'd7, 32'h14, C_LW, 32'h1000, 32'h0);
          sb.push_back(mk(1, 1, 32'h208, 32'h1000, 32'h0, 5'd2, 5'd0, 5'd7, 32'h14, C_LW, exp_cnt));
        end
        default: begin
          set_id(1, 32'h20C, 5'd1, 5'd7, 1, 0, 5'd8, 32'h0, C_ADD, 32'h5, 32'h6);
          sb.push_back(mk(1, 1, 32'h20C, 32'h5, 32'h6, 5'd1, 5'd7, 5'd8, 32'h0, C_ADD, exp_cnt));
        end
      endcase
      #1;
      checks++;
      if (stall_o !== exp_stall) begin
        errors++; $display("FAIL load_use_stall_%0d: got %b exp %b", i, stall_o, exp_stall);
      end
      step();
      e = sb.pop_front();
      o = get_obs();
      e = dc_fill(e, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL load_use_ex_%0d: got %h exp %h", i, o, e); end
    end
  endtask

  task automatic test_flush();
    exp_t e, o;
    for (int i = 0; i < 3; i++) begin
      flush_i = 1'b0;
      case (i)
        0: begin
          set_id(1, 32'h300, 5'd2, 5'd0, 1, 0, 5'd7, 32'h0, C_LW, 32'h2000, 32'h0);
          sb.push_back(mk(1, 1, 32'h300, 32'h2000, 32'h0, 5'd2, 5'd0, 5'd7, 32'h0, C_LW, exp_cnt));
        end
        1: begin
          set_id(1, 32'h304, 5'd7, 5'd1, 1, 1, 5'd8, 32'h0, C_ADD, 32'h0, 32'h3);
          flush_i = 1'b1;
          sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, exp_cnt));
        end
        default: begin
          set_id(1, 32'h304, 5'd7, 5'd1, 1, 1, 5'd8, 32'h0, C_ADD, 32'h9, 32'h3);
          sb.push_back(mk(1, 1, 32'h304, 32'h9, 32'h3, 5'd7, 5'd1, 5'd8, 32'h0, C_ADD, exp_cnt));
        end
      endcase
      #1;
      checks++;
      if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall_%0d: got %b exp 0", i, stall_o); end
      step();
      e = sb.pop_front();
      o = get_obs();
      e = dc_fill(e, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL flush_ex_%0d: got %h exp %h", i, o, e); end
    end
    flush_i = 1'b0;
  endtask

  task automatic test_back_pressure();
    exp_t e, o, a;
    logic exp_stall;
    a = mk(1, 1, 32'h400, 32'hAAAA, 32'hBBBB, 5'd3, 5'd4, 5'd5, 32'h20, C_ADD, exp_cnt);
    for (int i = 0; i < 5; i++) begin
      exp_stall = 1'b0;
      ex_stall_i = 1'b0;
      if (i == 0) begin
        set_id(1, 32'h400, 5'd3, 5'd4, 1, 1, 5'd5, 32'h20, C_ADD, 32'hAAAA, 32'hBBBB);
        sb.push_back(a);
      end else if (i < 4) begin
        set_id(1, 32'h404, 5'd5, 5'd6, 1, 1, 5'd9, 32'h24, 8'h11, 32'hC0DE, 32'hF00D);
        set_wb(1, 5'd3, 32'h99999999);
        ex_stall_i = 1'b1;
        exp_stall = 1'b1;
        sb.push_back(a);
      end else begin
        set_id(1, 32'h404, 5'd5, 5'd6, 1, 1, 5'd9, 32'h24, 8'h11, 32'hC0DE, 32'hF00D);
        set_wb(0, 0, 0);
        sb.push_back(mk(1, 1, 32'h404, 32'hC0DE, 32'hF00D, 5'd5, 5'd6, 5'd9, 32'h24, 8'h11, exp_cnt));
      end
      #1;
      checks++;
      if (stall_o !== exp_stall) begin
        errors++; $display("FAIL back_pressure_stall_%0d: got %b exp %b", i, stall_o, exp_stall);
      end
      step();
      e = sb.pop_front();
      o = get_obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL back_pressure_ex_%0d: got %h exp %h", i, o, e); end
    end
    ex_stall_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    logic [31:0] d1, d2;
    for (int i = 0; i < 4; i++) begin
      d1 = $urandom;
      d2 = $urandom;
      set_id(1, 32'h500 + 32'(i * 4), 5'(i + 10), 5'(i + 20), 1, 1, 5'(i + 1),
             32'(i), 8'hE1, d1, d2);
      sb.push_back(mk(1, 1, 32'h500 + 32'(i * 4), d1, d2, 5'(i + 10), 5'(i + 20), 5'(i + 1),
                      32'(i), 8'hE1, exp_cnt));
      step();
      e = sb.pop_front();
      o = get_obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back_%0d: got %h exp %h", i, o, e); end
    end
  endtask

  task automatic test_saturation();
    exp_t e, o;
    for (int i = 0; i < 60; i++) begin
      case (i % 3)
        0: begin
          set_id(1, 32'h600, 5'd2, 5'd0, 1, 0, 5'd7, 32'h0, C_LW, 32'h3000, 32'h0);
          sb.push_back(mk(1, 1, 32'h600, 32'h3000, 32'h0, 5'd2, 5'd0, 5'd7, 32'h0, C_LW, exp_cnt));
        end
        1: begin
          set_id(1, 32'h604, 5'd1, 5'd7, 1, 1, 5'd8, 32'h0, C_ADD, 32'h1, 32'h0);
          bump_cnt();
          sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, exp_cnt));
        end
        default: begin
          set_id(1, 32'h604, 5'd1, 5'd7, 1, 1, 5'd8, 32'h0, C_ADD, 32'h1, 32'h2);
          sb.push_back(mk(1, 1, 32'h604, 32'h1, 32'h2, 5'd1, 5'd7, 5'd8, 32'h0, C_ADD, exp_cnt));
        end
      endcase
      step();
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL saturation_%0d: got empty scoreboard exp entry", i);
      end else begin
        e = sb.pop_front();
        o = get_obs();
        e = dc_fill(e, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL saturation_%0d: got %h exp %h", i, o, e); end
      end
    end
    checks++;
    if (bubble_cnt_o !== 4'hF) begin
      errors++; $display("FAIL saturation_final: got %0d exp 15", bubble_cnt_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e, o;
    set_id(1, 32'h700, 5'd2, 5'd0, 1, 0, 5'd7, 32'h0, C_LW, 32'h4000, 32'h0);
    sb.push_back(mk(1, 1, 32'h700, 32'h4000, 32'h0, 5'd2, 5'd0, 5'd7, 32'h0, C_LW, exp_cnt));
    step();
    e = sb.pop_front();
    o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL mid_stall_load: got %h exp %h", o, e); end
    set_id(1, 32'h704, 5'd7, 5'd1, 1, 1, 5'd8, 32'h0, C_ADD, 32'h44, 32'h55);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL mid_stall_pre: got %b exp 1", stall_o); end
    #1 rst_n_i = 1'b0;
    #1;
    e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    o = get_obs();
    checks++;
    if (o !== e || stall_o !== 1'b0) begin
      errors++; $display("FAIL mid_stall_reset: got %h stall %b exp %h stall 0", o, stall_o, e);
    end
    @(negedge clock_i);
    rst_n_i = 1'b1;
    exp_cnt = 4'd0;
    sb.push_back(mk(1, 1, 32'h704, 32'h44, 32'h55, 5'd7, 5'd1, 5'd8, 32'h0, C_ADD, exp_cnt));
    step();
    e = sb.pop_front();
    o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL mid_stall_post: got %h exp %h", o, e); end
  endtask

  initial begin
    rst_n_i = 1'b0;
    flush_i = 1'b0;
    ex_stall_i = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    test_reset();
    test_bypass();
    test_load_use();
    test_flush();
    test_back_pressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
